// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Brief    : Shared types, default widths and helpers for the memory port
//            arbiter (state encoding, instruction-word select).
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 64;
    localparam int DATA_W_DEF = 64;

    // Explicit state codes so the encoding is stable across tools and
    // easy to recognise on a waveform.
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_REQ_I  = 3'd1;
    localparam logic [2:0] c_ST_WAIT_I = 3'd2;
    localparam logic [2:0] c_ST_REQ_D  = 3'd3;
    localparam logic [2:0] c_ST_WAIT_D = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = c_ST_IDLE,
        ST_REQ_I  = c_ST_REQ_I,
        ST_WAIT_I = c_ST_WAIT_I,
        ST_REQ_D  = c_ST_REQ_D,
        ST_WAIT_D = c_ST_WAIT_D
    } arb_state_t;

    // A 64-bit bus beat carries two 32-bit instructions; PC bit 2 picks one.
    function automatic logic [31:0] inst_word_sel(
        input logic [DATA_W_DEF-1:0] rdata,
        input logic                  upper
    );
        return upper ? rdata[63:32] : rdata[31:0];
    endfunction

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/arb_run_counter.sv
`default_nettype none
// ============================================================================
// Module   : arb_run_counter
// Brief    : Saturating up-counter with synchronous clear. Tracks how many
//            data-port grants were made back to back while fetch waited.
// Revision : 1.0 - initial release
// ============================================================================
module arb_run_counter #(
    parameter int MAX_COUNT = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0] r_count;

    // Clear wins over increment; increment stops once the ceiling is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule : arb_run_counter
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one external memory bus between instruction fetch and the
//            memory stage. One outstanding req/gnt/rvalid transaction at a
//            time, data port preferred with a bounded run, fetch responses
//            cancellable by a pipeline flush.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_DATA_RUN = 4,
    parameter int RUN_W        = 3
) (
    input  logic                clk,
    input  logic                rst,
    // instruction fetch requester
    input  logic                fetch_i_req,
    input  logic [ADDR_W-1:0]   fetch_i_addr,
    // memory stage requester
    input  logic                memory_i_req,
    input  logic                memory_i_wen,
    input  logic [ADDR_W-1:0]   memory_i_addr,
    input  logic [DATA_W-1:0]   memory_i_wdata,
    input  logic [DATA_W/8-1:0] memory_i_wstrb,
    // pipeline control
    input  logic                ctrl_i_flush,
    // external bus
    output logic                bus_o_req,
    output logic                bus_o_we,
    output logic [ADDR_W-1:0]   bus_o_addr,
    output logic [DATA_W-1:0]   bus_o_wdata,
    output logic [DATA_W/8-1:0] bus_o_wstrb,
    input  logic                bus_i_gnt,
    input  logic                bus_i_rvalid,
    input  logic [DATA_W-1:0]   bus_i_rdata,
    // responses
    output logic                fetch_o_valid,
    output logic [31:0]         fetch_o_inst,
    output logic                memory_o_valid,
    output logic [DATA_W-1:0]   memory_o_rdata,
    // hazard unit stalls
    output logic                arb_o_fetch_stall,
    output logic                arb_o_mem_stall
);

    localparam logic [RUN_W-1:0] c_MAX_RUN = RUN_W'(MAX_DATA_RUN);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic                w_pick_d;
    logic                w_pick_i;
    logic                w_run_inc;
    logic                w_run_clr;
    logic [RUN_W-1:0]    w_run_count;

    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    logic                r_inst_hi;
    logic                r_drop;

    logic                w_in_req_i;
    logic                w_in_wait_i;
    logic                w_in_wait_d;

    assign w_in_req_i  = (r_state == ST_REQ_I);
    assign w_in_wait_i = (r_state == ST_WAIT_I);
    assign w_in_wait_d = (r_state == ST_WAIT_D);

    // Run length only grows while fetch is actually being held off; any
    // fetch grant, or a data grant with nobody waiting, starts it over.
    assign w_run_inc = w_pick_d &&  fetch_i_req;
    assign w_run_clr = w_pick_i || (w_pick_d && !fetch_i_req);

    arb_run_counter #(
        .MAX_COUNT (MAX_DATA_RUN),
        .CNT_W     (RUN_W)
    ) u_run_counter (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_run_inc),
        .i_clr   (w_run_clr),
        .o_count (w_run_count)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration and transaction sequencing.
    always_comb begin
        w_state_nxt = r_state;
        w_pick_d    = 1'b0;
        w_pick_i    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (memory_i_req && (!fetch_i_req || (w_run_count < c_MAX_RUN))) begin
                    w_pick_d    = 1'b1;
                    w_state_nxt = ST_REQ_D;
                end else if (fetch_i_req) begin
                    w_pick_i    = 1'b1;
                    w_state_nxt = ST_REQ_I;
                end
            end
            ST_REQ_I:  if (bus_i_gnt)    w_state_nxt = ST_WAIT_I;
            ST_WAIT_I: if (bus_i_rvalid) w_state_nxt = ST_IDLE;
            ST_REQ_D:  if (bus_i_gnt)    w_state_nxt = ST_WAIT_D;
            ST_WAIT_D: if (bus_i_rvalid) w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture the winner's request fields so the bus sees them stable
    // until the grant, independent of what the requesters do meanwhile.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_inst_hi <= 1'b0;
        end else if (w_pick_d) begin
            r_addr    <= memory_i_addr;
            r_we      <= memory_i_wen;
            r_wdata   <= memory_i_wdata;
            r_wstrb   <= memory_i_wstrb;
            r_inst_hi <= 1'b0;
        end else if (w_pick_i) begin
            r_addr    <= fetch_i_addr;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_inst_hi <= fetch_i_addr[2];
        end
    end

    // Drop flag: a flush while a fetch is in flight marks its response as
    // stale. A flush coinciding with the response cycle is too late; that
    // instruction is delivered and discarded further down the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= 1'b0;
        end else if (w_in_wait_i && bus_i_rvalid) begin
            r_drop <= 1'b0;
        end else if (ctrl_i_flush && (w_in_req_i || w_in_wait_i)) begin
            r_drop <= 1'b1;
        end
    end

    assign bus_o_req   = w_in_req_i || (r_state == ST_REQ_D);
    assign bus_o_we    = r_we;
    assign bus_o_addr  = r_addr;
    assign bus_o_wdata = r_wdata;
    assign bus_o_wstrb = r_wstrb;

    assign fetch_o_valid  = w_in_wait_i && bus_i_rvalid && !r_drop;
    assign memory_o_valid = w_in_wait_d && bus_i_rvalid;

    // Data is passed straight through from the bus but held at zero outside
    // the valid pulse so idle cycles never show stale bus contents.
    assign fetch_o_inst   = fetch_o_valid  ? inst_word_sel(bus_i_rdata, r_inst_hi) : 32'd0;
    assign memory_o_rdata = memory_o_valid ? bus_i_rdata : '0;

    assign arb_o_fetch_stall = fetch_i_req  && !fetch_o_valid;
    assign arb_o_mem_stall   = memory_i_req && !memory_o_valid;

endmodule : mem_port_arbiter
`default_nettype wire
